// File: rtl/bp_pkg.sv
// Shared definitions for the two-way branch-predictor cache: way count and the per-entry layout.
// The entry layout is sized for the default geometry (AWIDTH=32, LINES=8, DWIDTH=2).
package bp_pkg;

   localparam int BP_WAYS   = 2;
   localparam int BP_TAG_W  = 29;
   localparam int BP_DATA_W = 2;

   typedef struct packed {
      logic                 valid;
      logic [BP_TAG_W-1:0]  tag;
      logic [BP_DATA_W-1:0] data;
   } bp_entry_t;

endpackage

// File: rtl/bp_cache_way.sv
// One way of the predictor cache: per-set entry storage, two read-port tag compares
// and a write-port lookup used by the top to choose the victim.
module bp_cache_way
   import bp_pkg::*;
#(
   parameter int LINES = 8,
   parameter int IB    = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IB-1:0]        ridx0_i,
   input  logic [BP_TAG_W-1:0]  rtag0_i,
   output logic                 rhit0_o,
   output logic [BP_DATA_W-1:0] rdata0_o,
   input  logic [IB-1:0]        ridx1_i,
   input  logic [BP_TAG_W-1:0]  rtag1_i,
   output logic                 rhit1_o,
   output logic [BP_DATA_W-1:0] rdata1_o,
   input  logic [IB-1:0]        widx_i,
   input  logic [BP_TAG_W-1:0]  wtag_i,
   input  logic [BP_DATA_W-1:0] wdata_i,
   input  logic                 we_i,
   output logic                 wvalid_o,
   output logic                 wmatch_o
);

   bp_entry_t entry_q [LINES];
   bp_entry_t rdEntry0;
   bp_entry_t rdEntry1;
   bp_entry_t wrEntry;

   assign rdEntry0 = entry_q[ridx0_i];
   assign rdEntry1 = entry_q[ridx1_i];
   assign wrEntry  = entry_q[widx_i];

   // Read data is forced to zero on a miss so the top can simply OR the two ways.
   assign rhit0_o  = rdEntry0.valid && (rdEntry0.tag == rtag0_i);
   assign rdata0_o = rhit0_o ? rdEntry0.data : '0;
   assign rhit1_o  = rdEntry1.valid && (rdEntry1.tag == rtag1_i);
   assign rdata1_o = rhit1_o ? rdEntry1.data : '0;

   assign wvalid_o = wrEntry.valid;
   assign wmatch_o = wrEntry.valid && (wrEntry.tag == wtag_i);

   // Only valid bits are cleared by reset; a write in the reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LINES; i++) begin
            entry_q[i].valid <= 1'b0;
         end
      end else if (we_i) begin
         entry_q[widx_i] <= '{valid: 1'b1, tag: wtag_i, data: wdata_i};
      end
   end

endmodule

// File: rtl/bp_cache_2way.sv
// Two-way set-associative predictor cache with two combinational read ports and one write port.
// Optional macro BP_CACHE_LRU_EN: read hits also steer the per-set replacement bit (LRU instead of FIFO).
module bp_cache_2way
   import bp_pkg::*;
#(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 2,
   parameter int LINES  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] ra0,
   output logic [DWIDTH-1:0] dout0,
   output logic              hit0,
   input  logic [AWIDTH-1:0] ra1,
   output logic [DWIDTH-1:0] dout1,
   output logic              hit1,
   input  logic [AWIDTH-1:0] wa,
   input  logic [DWIDTH-1:0] din,
   input  logic              we
);

   localparam int IB    = $clog2(LINES);
   localparam int TAG_W = AWIDTH - IB;

   logic [IB-1:0]      idx0;
   logic [IB-1:0]      idx1;
   logic [IB-1:0]      wIdx;
   logic [TAG_W-1:0]   tag0;
   logic [TAG_W-1:0]   tag1;
   logic [TAG_W-1:0]   wTag;

   logic [BP_WAYS-1:0] hit0Way;
   logic [BP_WAYS-1:0] hit1Way;
   logic [DWIDTH-1:0]  data0Way [BP_WAYS];
   logic [DWIDTH-1:0]  data1Way [BP_WAYS];
   logic [BP_WAYS-1:0] wValid;
   logic [BP_WAYS-1:0] wMatch;
   logic [BP_WAYS-1:0] wayWe;
   logic               wSel;

   logic [LINES-1:0]   rep_q;
   logic [LINES-1:0]   rep_d;

   assign idx0 = ra0[IB-1:0];
   assign tag0 = ra0[AWIDTH-1:IB];
   assign idx1 = ra1[IB-1:0];
   assign tag1 = ra1[AWIDTH-1:IB];
   assign wIdx = wa[IB-1:0];
   assign wTag = wa[AWIDTH-1:IB];

   for (genvar w = 0; w < BP_WAYS; w++) begin : g_way
      bp_cache_way #(
         .LINES (LINES),
         .IB    (IB)
      ) u_way (
         .clk      (clk),
         .reset    (reset),
         .ridx0_i  (idx0),
         .rtag0_i  (tag0),
         .rhit0_o  (hit0Way[w]),
         .rdata0_o (data0Way[w]),
         .ridx1_i  (idx1),
         .rtag1_i  (tag1),
         .rhit1_o  (hit1Way[w]),
         .rdata1_o (data1Way[w]),
         .widx_i   (wIdx),
         .wtag_i   (wTag),
         .wdata_i  (din),
         .we_i     (wayWe[w]),
         .wvalid_o (wValid[w]),
         .wmatch_o (wMatch[w])
      );
   end

   // A tag lives in at most one way, so ORing the zero-on-miss data is safe.
   assign hit0  = |hit0Way;
   assign dout0 = data0Way[0] | data0Way[1];
   assign hit1  = |hit1Way;
   assign dout1 = data1Way[0] | data1Way[1];

   // Victim choice: tag match first (keeps tags unique), then lowest invalid way, then rep.
   always_comb begin
      wSel = 1'b0;
      if (wMatch[0]) begin
         wSel = 1'b0;
      end else if (wMatch[1]) begin
         wSel = 1'b1;
      end else if (!wValid[0]) begin
         wSel = 1'b0;
      end else if (!wValid[1]) begin
         wSel = 1'b1;
      end else begin
         wSel = rep_q[wIdx];
      end
      wayWe[0] = we && !wSel;
      wayWe[1] = we && wSel;
   end

   // Later assignments win: port 1 over port 0, and a write over either read.
   always_comb begin
      rep_d = rep_q;
`ifdef BP_CACHE_LRU_EN
      if (hit0) begin
         rep_d[idx0] = ~hit0Way[1];
      end
      if (hit1) begin
         rep_d[idx1] = ~hit1Way[1];
      end
`endif
      if (we) begin
         rep_d[wIdx] = ~wSel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end

endmodule

// File: tb/tb_bp_cache_2way.sv
// Self-checking bench for bp_cache_2way: table-driven cycle vectors plus replacement sequences.
// Expected replacement outcomes follow BP_CACHE_LRU_EN when it is defined for the build.
module tb_bp_cache_2way;

   logic        clk;
   logic        reset;
   logic [31:0] ra0;
   logic [1:0]  dout0;
   logic        hit0;
   logic [31:0] ra1;
   logic [1:0]  dout1;
   logic        hit1;
   logic [31:0] wa;
   logic [1:0]  din;
   logic        we;

   typedef struct {
      logic        rst;
      logic        wen;
      logic [31:0] waddr;
      logic [1:0]  wdata;
      logic [31:0] r0;
      logic [31:0] r1;
      logic        eHit0;
      logic [1:0]  eDout0;
      logic        eHit1;
      logic [1:0]  eDout1;
   } vec_t;

   typedef struct {
      logic       hit0;
      logic [1:0] dout0;
      logic       hit1;
      logic [1:0] dout1;
      string      name;
   } exp_t;

   exp_t expQ[$];
   vec_t vecs[15];
   int   testsRun = 0;
   int   testsFailed = 0;

   bp_cache_2way #(
      .AWIDTH (32),
      .DWIDTH (2),
      .LINES  (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ra0   (ra0),
      .dout0 (dout0),
      .hit0  (hit0),
      .ra1   (ra1),
      .dout1 (dout1),
      .hit1  (hit1),
      .wa    (wa),
      .din   (din),
      .we    (we)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic rst, input logic wen, input logic [31:0] waddr,
                               input logic [1:0] wdata, input logic [31:0] r0, input logic [31:0] r1,
                               input logic eh0, input logic [1:0] ed0, input logic eh1, input logic [1:0] ed1);
      vec_t v;
      v.rst = rst; v.wen = wen; v.waddr = waddr; v.wdata = wdata; v.r0 = r0; v.r1 = r1;
      v.eHit0 = eh0; v.eDout0 = ed0; v.eHit1 = eh1; v.eDout1 = ed1;
      return v;
   endfunction

   // Drive one cycle's inputs and queue the outputs expected before the next edge.
   task automatic applyStimulus(input logic rst, input logic wen, input logic [31:0] waddr,
                                input logic [1:0] wdata, input logic [31:0] r0, input logic [31:0] r1,
                                input logic eh0, input logic [1:0] ed0, input logic eh1, input logic [1:0] ed1,
                                input string name);
      exp_t e;
      reset = rst; we = wen; wa = waddr; din = wdata; ra0 = r0; ra1 = r1;
      e.hit0 = eh0; e.dout0 = ed0; e.hit1 = eh1; e.dout1 = ed1; e.name = name;
      expQ.push_back(e);
   endtask

   // Sample mid-cycle, compare both ports against the oldest queued expectation, then advance.
   task automatic checkOutput();
      exp_t e;
      @(negedge clk);
      if (expQ.size() == 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         e = expQ.pop_front();
         testsRun++;
         if ({hit0, dout0} !== {e.hit0, e.dout0}) begin
            testsFailed++;
            $display("[TB] FAIL %s port0: got hit=%b dout=%b, expected hit=%b dout=%b",
                     e.name, hit0, dout0, e.hit0, e.dout0);
         end
         testsRun++;
         if ({hit1, dout1} !== {e.hit1, e.dout1}) begin
            testsFailed++;
            $display("[TB] FAIL %s port1: got hit=%b dout=%b, expected hit=%b dout=%b",
                     e.name, hit1, dout1, e.hit1, e.dout1);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic rst, input logic wen, input logic [31:0] waddr,
                       input logic [1:0] wdata, input logic [31:0] r0, input logic [31:0] r1,
                       input logic eh0, input logic [1:0] ed0, input logic eh1, input logic [1:0] ed1,
                       input string name);
      applyStimulus(rst, wen, waddr, wdata, r0, r1, eh0, ed0, eh1, ed1, name);
      checkOutput();
   endtask

   task automatic doReset();
      reset = 1'b1; we = 1'b0; wa = '0; din = '0; ra0 = '0; ra1 = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      // Vector table: rst we wa din ra0 ra1 | hit0 dout0 hit1 dout1 (outputs seen before the edge).
      vecs[0]  = mk(0, 0, 32'h0,          2'b00, 32'h7,          32'h0,          0, 2'b00, 0, 2'b00);
      vecs[1]  = mk(0, 1, 32'h7,          2'b11, 32'h7,          32'h3,          0, 2'b00, 0, 2'b00);
      vecs[2]  = mk(0, 0, 32'h0,          2'b00, 32'h7,          32'h1111_0007,  1, 2'b11, 0, 2'b00);
      vecs[3]  = mk(0, 1, 32'h1111_0007,  2'b00, 32'h7,          32'h1111_0007,  1, 2'b11, 0, 2'b00);
      vecs[4]  = mk(0, 0, 32'h0,          2'b00, 32'h7,          32'h1111_0007,  1, 2'b11, 1, 2'b00);
      vecs[5]  = mk(0, 1, 32'h3,          2'b10, 32'h1111_0007,  32'h3,          1, 2'b00, 0, 2'b00);
      vecs[6]  = mk(0, 0, 32'h0,          2'b00, 32'h103,        32'h3,          0, 2'b00, 1, 2'b10);
      vecs[7]  = mk(0, 1, 32'h7,          2'b01, 32'h7,          32'h1111_0007,  1, 2'b11, 1, 2'b00);
      vecs[8]  = mk(0, 0, 32'h0,          2'b00, 32'h7,          32'h1111_0007,  1, 2'b01, 1, 2'b00);
      vecs[9]  = mk(0, 0, 32'h0,          2'b00, 32'h2222_0007,  32'h0,          0, 2'b00, 0, 2'b00);
      vecs[10] = mk(0, 1, 32'h4,          2'b11, 32'h4,          32'h5,          0, 2'b00, 0, 2'b00);
      vecs[11] = mk(1, 1, 32'h5,          2'b01, 32'h4,          32'h7,          1, 2'b11, 1, 2'b01);
      vecs[12] = mk(0, 0, 32'h0,          2'b00, 32'h5,          32'h7,          0, 2'b00, 0, 2'b00);
      vecs[13] = mk(0, 0, 32'h0,          2'b00, 32'h4,          32'h1111_0007,  0, 2'b00, 0, 2'b00);
      vecs[14] = mk(0, 0, 32'h0,          2'b00, 32'h3,          32'h2222_0007,  0, 2'b00, 0, 2'b00);

      doReset();
      for (int i = 0; i < 15; i++) begin
         step(vecs[i].rst, vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].r0, vecs[i].r1,
              vecs[i].eHit0, vecs[i].eDout0, vecs[i].eHit1, vecs[i].eDout1, $sformatf("vec%0d", i));
      end

      // Replacement sequence on set 7; idle reads park on empty set 0.
      doReset();
      step(0, 1, 32'h7,         2'b11, 32'h0, 32'h0, 0, 2'b00, 0, 2'b00, "repFillA");
      step(0, 1, 32'h1111_0007, 2'b00, 32'h0, 32'h0, 0, 2'b00, 0, 2'b00, "repFillB");
      step(0, 0, 32'h0,         2'b00, 32'h7, 32'h0, 1, 2'b11, 0, 2'b00, "repHoldA");
      step(0, 1, 32'h2222_0007, 2'b10, 32'h0, 32'h0, 0, 2'b00, 0, 2'b00, "repFillC");
      step(0, 0, 32'h0,         2'b00, 32'h2222_0007, 32'h0, 1, 2'b10, 0, 2'b00, "repReadC");
`ifdef BP_CACHE_LRU_EN
      step(0, 0, 32'h0,         2'b00, 32'h7, 32'h1111_0007, 1, 2'b11, 0, 2'b00, "repVictim");
      step(0, 1, 32'h3333_0007, 2'b01, 32'h0, 32'h0, 0, 2'b00, 0, 2'b00, "repFillD");
      step(0, 0, 32'h0,         2'b00, 32'h3333_0007, 32'h2222_0007, 1, 2'b01, 0, 2'b00, "repReadD");
`else
      step(0, 0, 32'h0,         2'b00, 32'h7, 32'h1111_0007, 0, 2'b00, 1, 2'b00, "repVictim");
      step(0, 1, 32'h3333_0007, 2'b01, 32'h0, 32'h0, 0, 2'b00, 0, 2'b00, "repFillD");
      step(0, 0, 32'h0,         2'b00, 32'h3333_0007, 32'h2222_0007, 1, 2'b01, 1, 2'b10, "repReadD");
`endif

      // Reset in the middle of a burst of writes wins over the simultaneous write.
      step(0, 1, 32'h6,         2'b01, 32'h0, 32'h0, 0, 2'b00, 0, 2'b00, "rstFill");
      step(0, 1, 32'h1,         2'b10, 32'h6, 32'h0, 1, 2'b01, 0, 2'b00, "rstPre");
      step(1, 1, 32'h5,         2'b11, 32'h1, 32'h3333_0007, 1, 2'b10, 1, 2'b01, "rstEdge");
      step(0, 0, 32'h0,         2'b00, 32'h5, 32'h6, 0, 2'b00, 0, 2'b00, "rstAfterA");
      step(0, 0, 32'h0,         2'b00, 32'h1, 32'h3333_0007, 0, 2'b00, 0, 2'b00, "rstAfterB");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/bp_cache_2way.md
BP_CACHE_2WAY -- requirements
Module: bp_cache_2way

Interface
REQ-001 Parameters SHALL be: AWIDTH, 32, address width; DWIDTH, 2, payload width; LINES, 8, sets (power of two, >=2).
REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ra0  in  AWIDTH  read address port 0
- dout0  out  DWIDTH  read data port 0
- hit0  out  1  port 0 hit
- ra1  in  AWIDTH  read address port 1
- dout1  out  DWIDTH  read data port 1
- hit1  out  1  port 1 hit
- wa  in  AWIDTH  write address
- din  in  DWIDTH  write data
- we  in  1  write enable

Function
REQ-003 Organisation SHALL be 2-way set-associative; index = addr[IB-1:0], tag = addr[AWIDTH-1:IB], IB = clog2(LINES).
REQ-004 Each way/set entry SHALL hold a valid bit, a tag and DWIDTH data; each set SHALL hold one replacement bit, rep, which names the victim way.
REQ-005 Reads SHALL be combinational, zero latency: hit = valid & tag match in either way; dout = data of the matching way.
REQ-006 On a miss, dout SHALL be 0.
REQ-007 Both ways matching SHALL be impossible by construction; no tag is ever duplicated within a set.
REQ-008 A write with we=1 SHALL be applied at the rising edge and visible to reads from the next cycle.
REQ-009 Same-cycle read of wa SHALL return the pre-edge state, with no bypass.
REQ-010 Write tag hit SHALL update data in place in the matching way; the other way SHALL be untouched.
REQ-011 Write miss with an invalid way in the set SHALL fill the lowest-numbered invalid way.
REQ-012 Write miss with both ways valid SHALL overwrite way rep.
REQ-013 After any write, rep of that set SHALL point to the way not written.
REQ-014 we=0 SHALL leave tags, data and valid bits unchanged.

Reset
REQ-015 reset=1 at an edge SHALL clear every valid bit and every rep bit; hit0 and hit1 SHALL be 0 from the next cycle.
REQ-016 reset SHALL take priority over a simultaneous write; that write is dropped.
REQ-017 Data and tag arrays need not be reset.

Configuration
REQ-018 Macro BP_CACHE_LRU_EN defined: a read hit on port 0 or port 1 SHALL set rep of that set to the other way at the edge.
- Write update (REQ-013) overrides read updates to the same set.
- Port 1 overrides port 0 on the same set.
REQ-019 Macro BP_CACHE_LRU_EN undefined: rep SHALL change only on writes, giving FIFO replacement; reads have no side effects.

Structure
REQ-020 Shared package bp_pkg SHALL hold the way-count constant (2) and the entry typedef (valid, tag, data); index and tag widths SHALL be derived locally.
REQ-021 One sub-module, bp_cache_way (single-way storage plus tag compare, instantiated twice), SHALL be used; replacement logic stays in the top module.

Verification (LINES=8, DWIDTH=2)
REQ-022 Compulsory miss: ra0=0x7 after reset -> hit0=0. Write wa=0x7, din=11 -> next cycle hit0=1, dout0=11.
REQ-023 Conflict without eviction: write 0x0000_0007=11, then 0x1111_0007=00 -> ra0=0x7 gives hit0=1, dout0=11; ra1=0x1111_0007 gives hit1=1, dout1=00.
REQ-024 Replacement, same fills as REQ-023, then hold ra0=0x7 one cycle, then write 0x2222_0007=10:
- with BP_CACHE_LRU_EN: 0x7 hits, 0x1111_0007 misses.
- without BP_CACHE_LRU_EN: 0x7 misses, 0x1111_0007 hits.
- either case: 0x2222_0007 hits, dout=10.
REQ-025 In-place update: rewrite 0x7 with 01 while both ways are full -> 0x7 gives dout=01; the other tag still hits; no eviction.
REQ-026 Same-cycle read: ra1=wa=0x3, we=1 on a fresh set -> hit1=0 in the write cycle, hit1=1 in the next cycle.
REQ-027 Reset mid-operation: reset=1 together with we=1 to 0x5 -> next cycle all previously written addresses and 0x5 miss on both ports.
